stream_comp_loader: RTL

Upstream feeder for the stream-compute actor. Accepts a single serial word stream of packets (command word, length word, then `length` data words) over a valid/ready handshake. Demultiplexes each packet into writes on the command, length and data FIFOs that the actor's invoke/enable modules consume. Throttles itself from the FIFO population counts so that no FIFO is ever overfilled.

---
 rtl/stream_comp_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/stream_comp_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_comp_loader: splits cmd/len/data packets into three FIFOs with      |
// | population-based throttling; STREAM_LOADER_LEN_CHECK_EN rejects bad lens. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module stream_comp_loader #(
  parameter int WIDTH       = 5,
  parameter int BUFFER_SIZE = 10,
  parameter int MAX_LEN     = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_word,
  input  logic [$clog2(BUFFER_SIZE)-1:0] pop_in_command_fifo,
  input  logic [$clog2(BUFFER_SIZE)-1:0] pop_in_length_fifo,
  input  logic [$clog2(BUFFER_SIZE)-1:0] pop_in_data_fifo,
  output logic                           wr_en_input,
  output logic [WIDTH-1:0]               command_in,
  output logic [WIDTH-1:0]               length_in,
  output logic                           wr_en_input_data,
  output logic [WIDTH-1:0]               data_in,
  output logic [1:0]                     state,
  output logic                           pkt_done,
  output logic [7:0]                     pkt_count,
  output logic                           err_len
);

  localparam int POP_W = $clog2(BUFFER_SIZE);
  localparam int SUM_W = POP_W + 1;
  localparam logic [SUM_W-1:0] C_BUF_LIM = SUM_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cmd_q, cmd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] command_in_q, command_in_d;
  logic [WIDTH-1:0] length_in_q, length_in_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             wr_en_input_q, wr_en_input_d;
  logic             wr_en_input_data_q, wr_en_input_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic             err_len_q, err_len_d;
  logic [7:0]       pkt_count_q, pkt_count_d;

  logic [SUM_W-1:0] cmd_fill, len_fill, data_fill;
  logic             cmd_space, len_space, data_space;
  logic             accept;
  logic             len_reject;

  // The registered strobe stands in for the write the FIFO has not yet counted.
  always_comb begin
    cmd_fill   = SUM_W'(pop_in_command_fifo) + SUM_W'(wr_en_input_q);
    len_fill   = SUM_W'(pop_in_length_fifo)  + SUM_W'(wr_en_input_q);
    data_fill  = SUM_W'(pop_in_data_fifo)    + SUM_W'(wr_en_input_data_q);
    cmd_space  = (cmd_fill  < C_BUF_LIM);
    len_space  = (len_fill  < C_BUF_LIM);
    data_space = (data_fill < C_BUF_LIM);
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_CMD:  in_ready = 1'b1;
      ST_LEN:  in_ready = cmd_space && len_space;
      ST_DATA: in_ready = data_space;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef STREAM_LOADER_LEN_CHECK_EN
  assign len_reject = (in_word == '0) || (32'(in_word) > 32'(MAX_LEN));
`else
  assign len_reject = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    cmd_d              = cmd_q;
    rem_d              = rem_q;
    command_in_d       = command_in_q;
    length_in_d        = length_in_q;
    data_in_d          = data_in_q;
    wr_en_input_d      = 1'b0;
    wr_en_input_data_d = 1'b0;
    pkt_done_d         = 1'b0;
    err_len_d          = 1'b0;
    pkt_count_d        = pkt_count_q;

    case (state_q)
      ST_CMD: begin
        if (accept) begin
          cmd_d   = in_word;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (accept) begin
          if (len_reject) begin
            err_len_d = 1'b1;
            state_d   = ST_CMD;
          end else begin
            wr_en_input_d = 1'b1;
            command_in_d  = cmd_q;
            length_in_d   = in_word;
            rem_d         = in_word;
            if (in_word == '0) begin
              pkt_done_d  = 1'b1;
              pkt_count_d = pkt_count_q + 8'd1;
              state_d     = ST_CMD;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          wr_en_input_data_d = 1'b1;
          data_in_d          = in_word;
          rem_d              = rem_q - 1'b1;
          if (rem_q == WIDTH'(1)) begin
            pkt_done_d  = 1'b1;
            pkt_count_d = pkt_count_q + 8'd1;
            state_d     = ST_CMD;
          end
        end
      end

      default: state_d = ST_CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_CMD;
      cmd_q              <= '0;
      rem_q              <= '0;
      command_in_q       <= '0;
      length_in_q        <= '0;
      data_in_q          <= '0;
      wr_en_input_q      <= 1'b0;
      wr_en_input_data_q <= 1'b0;
      pkt_done_q         <= 1'b0;
      err_len_q          <= 1'b0;
      pkt_count_q        <= 8'd0;
    end else begin
      state_q            <= state_d;
      cmd_q              <= cmd_d;
      rem_q              <= rem_d;
      command_in_q       <= command_in_d;
      length_in_q        <= length_in_d;
      data_in_q          <= data_in_d;
      wr_en_input_q      <= wr_en_input_d;
      wr_en_input_data_q <= wr_en_input_data_d;
      pkt_done_q         <= pkt_done_d;
      err_len_q          <= err_len_d;
      pkt_count_q        <= pkt_count_d;
    end
  end

  assign state            = state_q;
  assign wr_en_input      = wr_en_input_q;
  assign command_in       = command_in_q;
  assign length_in        = length_in_q;
  assign wr_en_input_data = wr_en_input_data_q;
  assign data_in          = data_in_q;
  assign pkt_done         = pkt_done_q;
  assign pkt_count        = pkt_count_q;
  assign err_len          = err_len_q;

endmodule

`default_nettype wire
